// File: rtl/traffic_driver.sv
// traffic_driver
//   Sequences a traffic block through one run: Init with the packet total,
//   Fill with a programmed number of descriptors, then PreDeque/Dequeue
//   flits while downstream credits are available, until traffic_done.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run request, sampled only while idle
//   cfg_num_desc          descriptors to load (latched with start)
//   cfg_total             packet total for the traffic block (latched with start)
//   desc_valid/desc_data  descriptor source; desc_ready acknowledges it
//   credit_ret            one flit credit returned by downstream
//   traffic_done          traffic block reports completion
//   op/data               opcode and payload to the traffic block
//   flit_valid            registered: a flit was issued on the previous cycle
//   busy                  high whenever a run is in progress
//   err                   sticky: credit returned while already at full credits

`ifndef TRAFFIC_DRIVER_DEFS
`define TRAFFIC_DRIVER_DEFS
`define DataBitSize 16
`define DataDst 3:0
`define DataVc 5:4
`define DataNumFlit 15:6
`define InitTrafficTotalNumTraffic 15:0
`define OP_SIZE 3
`define NOP 3'd0
`define Init 3'd1
`define Fill 3'd2
`define PreDeque 3'd3
`define Dequeue 3'd4
`endif

module traffic_driver #(
  parameter int unsigned CREDITS = 8,
  parameter int unsigned CNT_W   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        cfg_num_desc,
  input  logic [CNT_W-1:0]        cfg_total,
  input  logic                    desc_valid,
  input  logic [`DataBitSize-1:0] desc_data,
  output logic                    desc_ready,
  input  logic                    credit_ret,
  input  logic                    traffic_done,
  output logic [`OP_SIZE-1:0]     op,
  output logic [`DataBitSize-1:0] data,
  output logic                    flit_valid,
  output logic                    busy,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FILL,
    S_PRE,
    S_RUN,
    S_FIN
  } state_e;

  localparam logic [4:0] CRED_MAX = 5'(CREDITS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_desc_q, num_desc_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [4:0]       credits_q, credits_d;
  logic             flit_valid_q;
  logic             err_q, err_d;
  logic             can_issue;
  logic             issue;
  logic             ret_ok;

  assign can_issue = (credits_q != '0);

  always_comb begin
    state_d    = state_q;
    num_desc_d = num_desc_q;
    total_d    = total_q;
    fill_cnt_d = fill_cnt_q;
    op         = `NOP;
    data       = '0;
    desc_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_desc_d = cfg_num_desc;
          total_d    = cfg_total;
          fill_cnt_d = '0;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        op      = `Init;
        data[`InitTrafficTotalNumTraffic] = `DataBitSize'(total_q);
        state_d = (num_desc_q == '0) ? S_FIN : S_FILL;
      end
      S_FILL: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          op         = `Fill;
          data       = desc_data;
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
          // Leave on the handshake that completes the load, so the
          // cycle after the last Fill never shows desc_ready.
          if (fill_cnt_d == num_desc_q) state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (traffic_done) begin
          state_d = S_FIN;
        end else if (can_issue) begin
          op      = `PreDeque;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (traffic_done) begin
          state_d = S_FIN;
        end else if (can_issue) begin
          op = `Dequeue;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A return at full credits is dropped (and flagged); otherwise an issue
  // and a return in the same cycle cancel out.
  assign issue  = (op == `PreDeque) || (op == `Dequeue);
  assign ret_ok = credit_ret && (credits_q != CRED_MAX);
  assign err_d  = err_q | (credit_ret & ~ret_ok);

  always_comb begin
    credits_d = credits_q;
    if (issue && !ret_ok) begin
      credits_d = credits_q - 5'd1;
    end else if (!issue && ret_ok) begin
      credits_d = credits_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      num_desc_q   <= '0;
      total_q      <= '0;
      fill_cnt_q   <= '0;
      credits_q    <= CRED_MAX;
      flit_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_desc_q   <= num_desc_d;
      total_q      <= total_d;
      fill_cnt_q   <= fill_cnt_d;
      credits_q    <= credits_d;
      flit_valid_q <= issue;
      err_q        <= err_d;
    end
  end

  assign flit_valid = flit_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_traffic_driver.sv
// tb_traffic_driver
//   Directed vector tables and hand sequences for the run sequencing and
//   credit corner cases, followed by randomized traffic compared cycle by
//   cycle against a phase/credit model of the driver.

`ifndef TRAFFIC_DRIVER_DEFS
`define TRAFFIC_DRIVER_DEFS
`define DataBitSize 16
`define DataDst 3:0
`define DataVc 5:4
`define DataNumFlit 15:6
`define InitTrafficTotalNumTraffic 15:0
`define OP_SIZE 3
`define NOP 3'd0
`define Init 3'd1
`define Fill 3'd2
`define PreDeque 3'd3
`define Dequeue 3'd4
`endif

module tb_traffic_driver;

  localparam int CREDITS = 8;
  localparam int CNT_W   = 10;
  localparam int DW      = `DataBitSize;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] cfg_num_desc;
  logic [CNT_W-1:0] cfg_total;
  logic             desc_valid;
  logic [DW-1:0]    desc_data;
  logic             desc_ready;
  logic             credit_ret;
  logic             traffic_done;
  logic [`OP_SIZE-1:0] op;
  logic [DW-1:0]    data;
  logic             flit_valid;
  logic             busy;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  traffic_driver #(.CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_num_desc (cfg_num_desc),
    .cfg_total    (cfg_total),
    .desc_valid   (desc_valid),
    .desc_data    (desc_data),
    .desc_ready   (desc_ready),
    .credit_ret   (credit_ret),
    .traffic_done (traffic_done),
    .op           (op),
    .data         (data),
    .flit_valid   (flit_valid),
    .busy         (busy),
    .err          (err)
  );

  typedef struct {
    logic          s;
    logic          v;
    logic          r;
    logic          d;
    logic [DW-1:0] desc;
    logic [2:0]    e_op;
    logic [DW-1:0] e_data;
    logic          e_ready;
    logic          e_busy;
    logic          e_fv;
  } vec_t;

  vec_t va[10];
  vec_t vb[7];

  function automatic vec_t mk(input logic s, input logic v, input logic r, input logic d,
                              input logic [DW-1:0] desc, input logic [2:0] e_op,
                              input logic [DW-1:0] e_data, input logic e_ready,
                              input logic e_busy, input logic e_fv);
    vec_t t;
    t.s = s; t.v = v; t.r = r; t.d = d; t.desc = desc;
    t.e_op = e_op; t.e_data = e_data; t.e_ready = e_ready;
    t.e_busy = e_busy; t.e_fv = e_fv;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, settle 1 time unit.
  task automatic drive(input logic s, input logic v, input logic r, input logic d,
                       input logic [DW-1:0] dd);
    @(negedge clk);
    start = s; desc_valid = v; credit_ret = r; traffic_done = d; desc_data = dd;
    #1;
  endtask

  task automatic apply_vec(input string tag, input vec_t t);
    drive(t.s, t.v, t.r, t.d, t.desc);
    check({tag, ".op"},    32'(op),         32'(t.e_op));
    check({tag, ".data"},  32'(data),       32'(t.e_data));
    check({tag, ".ready"}, 32'(desc_ready), 32'(t.e_ready));
    check({tag, ".busy"},  32'(busy),       32'(t.e_busy));
    check({tag, ".fv"},    32'(flit_valid), 32'(t.e_fv));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".op"},    32'(op),         32'(`NOP));
    check({tag, ".data"},  32'(data),       32'd0);
    check({tag, ".ready"}, 32'(desc_ready), 32'd0);
    check({tag, ".busy"},  32'(busy),       32'd0);
    check({tag, ".fv"},    32'(flit_valid), 32'd0);
    check({tag, ".err"},   32'(err),        32'd0);
  endtask

  // Reference model: a run is IDLE -> INIT -> LOAD (count descriptors down)
  // -> DRAIN (first issue is PreDeque, later ones Dequeue) -> FIN -> IDLE.
  localparam int P_IDLE = 0, P_INIT = 1, P_LOAD = 2, P_DRAIN = 3, P_FIN = 4;
  int            m_phase;
  int            m_left;
  int            m_total;
  int            m_cred;
  bit            m_sent;
  bit            m_err;
  bit            m_fv;

  function automatic void model_reset();
    m_phase = P_IDLE; m_left = 0; m_total = 0; m_cred = CREDITS;
    m_sent = 0; m_err = 0; m_fv = 0;
  endfunction

  initial begin
    logic [2:0]    e_op;
    logic [DW-1:0] e_data;
    bit            e_ready;
    bit            issued;
    bit            ret_taken;

    rst_n = 1'b0; start = 0; desc_valid = 0; credit_ret = 0; traffic_done = 0;
    desc_data = '0; cfg_num_desc = '0; cfg_total = '0;
    #1;
    check_reset_outputs("por");
    #11 rst_n = 1'b1;

    // ---- Sequence A: load 3, issue until credits are exhausted ----
    cfg_num_desc = 10'd3; cfg_total = 10'd2;
    va[0] = mk(1, 1, 0, 0, 16'hA000, `NOP,      16'h0,    0, 0, 0);
    va[1] = mk(1, 1, 0, 0, 16'hA001, `Init,     16'h2,    0, 1, 0);
    va[2] = mk(0, 1, 0, 0, 16'hA002, `Fill,     16'hA002, 1, 1, 0);
    va[3] = mk(0, 1, 0, 0, 16'hA003, `Fill,     16'hA003, 1, 1, 0);
    va[4] = mk(0, 1, 0, 0, 16'hA004, `Fill,     16'hA004, 1, 1, 0);
    va[5] = mk(0, 1, 0, 0, 16'hA005, `PreDeque, 16'h0,    0, 1, 0);
    for (int i = 6; i < 10; i++)
      va[i] = mk(0, 1, 0, 0, DW'(16'hA000 + i), `Dequeue, 16'h0, 0, 1, 1);
    for (int i = 0; i < 10; i++) apply_vec($sformatf("A%0d", i), va[i]);

    // Five issued so far; three more drain the eight credits.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, '0);
      check($sformatf("drain%0d.op", i), 32'(op), 32'(`Dequeue));
    end
    drive(0, 1, 0, 0, '0);
    check("empty.op", 32'(op), 32'(`NOP));
    check("empty.fv", 32'(flit_valid), 32'd1);
    drive(0, 1, 1, 0, '0);
    check("ret1.op", 32'(op), 32'(`NOP));
    check("ret1.fv", 32'(flit_valid), 32'd0);
    drive(0, 1, 0, 0, '0);
    check("one_more.op", 32'(op), 32'(`Dequeue));
    drive(0, 1, 1, 0, '0);
    check("empty2.op", 32'(op), 32'(`NOP));
    check("empty2.fv", 32'(flit_valid), 32'd1);
    // credits==1: return and issue together keep it at 1.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 0, '0);
      check($sformatf("bal%0d.op", i), 32'(op), 32'(`Dequeue));
    end
    drive(0, 1, 0, 0, '0);
    check("bal_last.op", 32'(op), 32'(`Dequeue));
    drive(0, 1, 0, 0, '0);
    check("bal_empty.op", 32'(op), 32'(`NOP));
    drive(0, 1, 0, 1, '0);
    check("done.op", 32'(op), 32'(`NOP));
    check("done.busy", 32'(busy), 32'd1);
    drive(0, 1, 0, 0, '0);
    check("fin.op", 32'(op), 32'(`NOP));
    check("fin.busy", 32'(busy), 32'd1);
    drive(0, 1, 0, 0, '0);
    check("idle.busy", 32'(busy), 32'd0);
    check("idle.ready", 32'(desc_ready), 32'd0);
    for (int i = 0; i < CREDITS; i++) begin
      drive(0, 0, 1, 0, '0);
      check($sformatf("refill%0d.err", i), 32'(err), 32'd0);
    end
    drive(0, 0, 1, 0, '0);
    check("overret.err", 32'(err), 32'd0);
    drive(0, 0, 0, 0, '0);
    check("err_set", 32'(err), 32'd1);
    drive(0, 0, 0, 0, '0);
    check("err_sticky", 32'(err), 32'd1);

    // ---- Asynchronous reset in the middle of RUN ----
    cfg_num_desc = 10'd1; cfg_total = 10'd7;
    drive(1, 1, 0, 0, 16'h0C01);
    drive(0, 1, 0, 0, 16'h0C02);
    drive(0, 1, 0, 0, 16'h0C03);
    drive(0, 1, 0, 0, 16'h0C04);
    drive(0, 1, 0, 0, 16'h0C05);
    check("prerst.op", 32'(op), 32'(`Dequeue));
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    #1 rst_n = 1'b1;

    // ---- Sequence B: first run after reset, gapped descriptors ----
    cfg_num_desc = 10'd2; cfg_total = 10'd5;
    vb[0] = mk(1, 1, 0, 0, 16'hB000, `NOP,      16'h0,    0, 0, 0);
    vb[1] = mk(0, 0, 0, 0, 16'hB001, `Init,     16'h5,    0, 1, 0);
    vb[2] = mk(0, 1, 0, 0, 16'hB002, `Fill,     16'hB002, 1, 1, 0);
    vb[3] = mk(0, 0, 0, 0, 16'hB003, `NOP,      16'h0,    1, 1, 0);
    vb[4] = mk(0, 1, 0, 0, 16'hB004, `Fill,     16'hB004, 1, 1, 0);
    vb[5] = mk(0, 0, 0, 0, 16'hB005, `PreDeque, 16'h0,    0, 1, 0);
    vb[6] = mk(0, 1, 0, 0, 16'hB006, `Dequeue,  16'h0,    0, 1, 1);
    for (int i = 0; i < 7; i++) apply_vec($sformatf("B%0d", i), vb[i]);
    drive(0, 0, 0, 1, '0);
    check("B.done.op", 32'(op), 32'(`NOP));
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);
    check("B.idle.busy", 32'(busy), 32'd0);

    // ---- Zero descriptors: Init then straight to FIN ----
    cfg_num_desc = 10'd0; cfg_total = 10'd9;
    drive(1, 0, 0, 0, '0);
    drive(0, 1, 0, 0, '0);
    check("z.init.op", 32'(op), 32'(`Init));
    check("z.init.data", 32'(data), 32'd9);
    drive(0, 1, 0, 0, '0);
    check("z.fin.op", 32'(op), 32'(`NOP));
    check("z.fin.ready", 32'(desc_ready), 32'd0);
    check("z.fin.busy", 32'(busy), 32'd1);
    drive(0, 1, 0, 0, '0);
    check("z.idle.busy", 32'(busy), 32'd0);

    // ---- Randomized traffic against the model ----
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) begin
        #1 rst_n = 1'b0;
        #1 check_reset_outputs($sformatf("rnd%0d.rst", cyc));
        model_reset();
        #1 rst_n = 1'b1;
      end
      start        = ($urandom_range(0, 3) == 0);
      cfg_num_desc = CNT_W'($urandom_range(0, 4));
      cfg_total    = CNT_W'($urandom);
      desc_valid   = 1'($urandom_range(0, 1));
      desc_data    = DW'($urandom);
      credit_ret   = ($urandom_range(0, 2) == 0);
      traffic_done = ($urandom_range(0, 15) == 0);
      #1;

      e_op = `NOP; e_data = '0; e_ready = 0;
      case (m_phase)
        P_INIT: begin e_op = `Init; e_data = DW'(m_total); end
        P_LOAD: begin
          e_ready = 1;
          if (desc_valid) begin e_op = `Fill; e_data = desc_data; end
        end
        P_DRAIN: if (!traffic_done && m_cred > 0) e_op = m_sent ? `Dequeue : `PreDeque;
        default: ;
      endcase

      check($sformatf("rnd%0d.op", cyc),    32'(op),         32'(e_op));
      check($sformatf("rnd%0d.data", cyc),  32'(data),       32'(e_data));
      check($sformatf("rnd%0d.ready", cyc), 32'(desc_ready), 32'(e_ready));
      check($sformatf("rnd%0d.busy", cyc),  32'(busy),       32'(m_phase != P_IDLE));
      check($sformatf("rnd%0d.fv", cyc),    32'(flit_valid), 32'(m_fv));
      check($sformatf("rnd%0d.err", cyc),   32'(err),        32'(m_err));

      issued    = (e_op == `PreDeque) || (e_op == `Dequeue);
      ret_taken = credit_ret && (m_cred < CREDITS);
      if (credit_ret && !ret_taken) m_err = 1;
      m_cred = m_cred - int'(issued) + int'(ret_taken);
      m_fv   = issued;
      case (m_phase)
        P_IDLE: if (start) begin
          m_total = int'(cfg_total); m_left = int'(cfg_num_desc); m_phase = P_INIT;
        end
        P_INIT: begin m_phase = (m_left == 0) ? P_FIN : P_LOAD; m_sent = 0; end
        P_LOAD: if (desc_valid) begin
          m_left--;
          if (m_left == 0) m_phase = P_DRAIN;
        end
        P_DRAIN: begin
          if (traffic_done) m_phase = P_FIN;
          else if (issued) m_sent = 1;
        end
        default: m_phase = P_IDLE;
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_driver.md
TRAFFIC_DRIVER -- requirements
Module: traffic_driver

Interface
REQ-001 SHALL have parameter CREDITS, default 8, meaning the initial downstream flit credit count (legal range 1..31).
REQ-002 SHALL have parameter CNT_W, default 10, meaning the width of the packet/descriptor counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a run; sampled only in IDLE.
REQ-006 cfg_num_desc  input  CNT_W  number of descriptors to load; sampled with start.
REQ-007 cfg_total  input  CNT_W  total packet count for the traffic block; sampled with start.
REQ-008 desc_valid  input  1  descriptor available on desc_data.
REQ-009 desc_data  input  `DataBitSize  descriptor (`DataDst, `DataVc, `DataNumFlit fields).
REQ-010 desc_ready  output  1  driver accepts desc_data this cycle.
REQ-011 credit_ret  input  1  downstream returns one flit credit.
REQ-012 traffic_done  input  1  done flag from the traffic block.
REQ-013 op  output  `op_size  opcode to the traffic block (`NOP/`Init/`Fill/`PreDeque/`Dequeue).
REQ-014 data  output  `DataBitSize  data to the traffic block.
REQ-015 flit_valid  output  1  traffic buffer holds a new flit this cycle.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL implement FSM states IDLE, INIT, FILL, PRE, RUN, FIN; op, data, desc_ready SHALL be combinational from state and inputs.
REQ-019 IDLE: op=`NOP; start=1 -> latch cfg_num_desc/cfg_total, go to INIT.
REQ-020 INIT: for exactly one cycle, op=`Init and data`InitTrafficTotalNumTraffic=latched cfg_total (other bits 0); then go to FILL, or to FIN if cfg_num_desc=0.
REQ-021 FILL: desc_ready=1; when desc_valid&desc_ready, op=`Fill, data=desc_data, and fill_cnt increments; otherwise op=`NOP.
REQ-022 FILL: on the handshake that makes fill_cnt equal num_desc, go to PRE; no further descriptors are accepted.
REQ-023 PRE: when credits>0 and traffic_done=0, op=`PreDeque for one cycle, then go to RUN; when credits=0, op=`NOP and remain; when traffic_done=1, go to FIN.
REQ-024 RUN: op=`Dequeue on every cycle with credits>0 and traffic_done=0; op=`NOP when credits=0.
REQ-025 RUN: traffic_done=1 -> op=`NOP that cycle, go to FIN.
REQ-026 FIN: op=`NOP for one cycle, then go to IDLE.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 Credit counter (5 bits): decrement on each cycle that op is `PreDeque or `Dequeue; increment on credit_ret; a simultaneous decrement and increment leaves it unchanged.
REQ-029 credit_ret while the counter equals CREDITS SHALL be ignored and SHALL set err; an issue with credits=0 SHALL never occur.
REQ-030 flit_valid SHALL be registered: high in cycle N+1 iff op was `PreDeque or `Dequeue in cycle N.
REQ-031 desc_ready SHALL be 0 outside FILL; desc_valid outside FILL SHALL have no effect.
REQ-032 Counters SHALL be CNT_W bits wide and SHALL not wrap within a run.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, fill_cnt=0, credits=CREDITS, flit_valid=0, err=0, so that op=`NOP, data=0, desc_ready=0, busy=0.
REQ-034 Reset asserted mid-run SHALL abandon the run with no residual op; the first run after release SHALL behave identically to a run after power-up.

Verification
REQ-035 start, num_desc=3, total=2, desc_valid always 1 -> Init for 1 cycle, Fill for 3 consecutive cycles, PreDeque, then Dequeue each cycle.
REQ-036 CREDITS=8, no credit_ret -> exactly 8 issues (1 PreDeque + 7 Dequeue), then op=`NOP; one credit_ret -> exactly one more Dequeue.
REQ-037 credit_ret on the same cycle as a Dequeue with credits=1 -> credits stay 1, Dequeue continues every cycle.
REQ-038 desc_valid toggled 1,0,1,0 with num_desc=2 -> Fill only on the valid cycles; PRE is entered after the 2nd Fill.
REQ-039 traffic_done raised during RUN -> op=`NOP in that cycle, FIN, then IDLE, busy=0; credit_ret at full credits -> err=1.
REQ-040 rst_n low during RUN -> op=`NOP and busy=0 with no clock edge; a new start runs the full sequence from Init.
